// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter sweep sequencer and its optional checker.
package counter_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      UP,
      DOWN,
      DONE
   } sweep_state_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_sweep_chk.sv
// Count predictor and sticky mismatch flag for the sweep sequencer.
// Built only when COUNTER_SWEEP_CHK_EN is defined.
module counter_sweep_chk
   import counter_ctrl_pkg::*;
#(
   parameter int COUNT_WD = 16
) (
   input  logic                i_clk,
   input  logic                i_rstb,
   input  logic                i_clear,
   input  logic                i_chk_en,
   input  logic                i_tm_reset,
   input  logic                i_tm_direction,
   input  logic [COUNT_WD-1:0] i_count,
   output logic                o_mismatch
);

   logic [COUNT_WD-1:0] pred;

   // Mirror the counter contract from the controls actually driven.
   always_ff @(posedge i_clk or negedge i_rstb) begin
      if (!i_rstb) begin
         pred <= '0;
      end else if (i_tm_reset) begin
         pred <= '0;
      end else if (i_tm_direction == DIR_UP) begin
         pred <= pred + COUNT_WD'(1);
      end else begin
         pred <= pred - COUNT_WD'(1);
      end
   end

   // Sticky flag: a new accepted start wins over a same-cycle mismatch.
   always_ff @(posedge i_clk or negedge i_rstb) begin
      if (!i_rstb) begin
         o_mismatch <= 1'b0;
      end else if (i_clear) begin
         o_mismatch <= 1'b0;
      end else if (i_chk_en && (i_count != pred)) begin
         o_mismatch <= 1'b1;
      end
   end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for the test-mode counter: 0 -> limit -> 0,
// repeated a programmed number of times, with busy/done/progress status.
// Optional self-check port o_mismatch is built under COUNTER_SWEEP_CHK_EN.
module counter_sweep_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int COUNT_WD = 16,
   parameter int SWEEP_WD = 8
) (
   input  logic                i_clk,
   input  logic                i_rstb,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic [COUNT_WD-1:0] i_limit,
   input  logic [SWEEP_WD-1:0] i_num_sweeps,
   input  logic [COUNT_WD-1:0] i_count,
   output logic                o_tm_reset,
   output logic                o_tm_direction,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_start_err,
   output logic [SWEEP_WD-1:0] o_sweep_cnt
`ifdef COUNTER_SWEEP_CHK_EN
   ,
   output logic                o_mismatch
`endif
);

   sweep_state_e        state;
   logic [COUNT_WD-1:0] lim_q;
   logic [SWEEP_WD-1:0] nsw_q;
   logic [SWEEP_WD-1:0] sweep_inc;
   logic                start_req;
   logic                start_ok;
   logic                start_bad;

   function automatic logic [SWEEP_WD-1:0] sat_inc(input logic [SWEEP_WD-1:0] v);
      if (&v) begin
         return v;
      end
      return v + SWEEP_WD'(1);
   endfunction

   assign start_req = (state == IDLE) && i_start;
   assign start_ok  = start_req && (i_limit != '0) && (i_num_sweeps != '0);
   assign start_bad = start_req && !start_ok;
   assign sweep_inc = sat_inc(o_sweep_cnt);

   // Run parameters are data only; captured once per accepted start.
   always_ff @(posedge i_clk) begin
      if (start_ok) begin
         lim_q <= i_limit;
         nsw_q <= i_num_sweeps;
      end
   end

   // Sequencer: outputs are registered alongside the state they belong to.
   // UP exits one count early so the peak appears for exactly one sample.
   always_ff @(posedge i_clk or negedge i_rstb) begin
      if (!i_rstb) begin
         state          <= IDLE;
         o_tm_reset     <= 1'b1;
         o_tm_direction <= DIR_UP;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
         o_start_err    <= 1'b0;
         o_sweep_cnt    <= '0;
      end else begin
         o_done      <= 1'b0;
         o_start_err <= 1'b0;
         if ((state != IDLE) && i_abort) begin
            state          <= IDLE;
            o_tm_reset     <= 1'b1;
            o_tm_direction <= DIR_UP;
            o_busy         <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  o_tm_reset     <= 1'b1;
                  o_tm_direction <= DIR_UP;
                  if (start_ok) begin
                     o_sweep_cnt <= '0;
                     o_busy      <= 1'b1;
                     state       <= CLEAR;
                  end else if (start_bad) begin
                     o_start_err <= 1'b1;
                  end
               end
               CLEAR: begin
                  o_tm_reset     <= 1'b0;
                  o_tm_direction <= DIR_UP;
                  state          <= UP;
               end
               UP: begin
                  if (i_count == (lim_q - COUNT_WD'(1))) begin
                     o_tm_direction <= DIR_DOWN;
                     state          <= DOWN;
                  end
               end
               DOWN: begin
                  if (i_count == COUNT_WD'(1)) begin
                     o_sweep_cnt <= sweep_inc;
                     if (sweep_inc == nsw_q) begin
                        o_tm_reset <= 1'b1;
                        o_done     <= 1'b1;
                        o_busy     <= 1'b0;
                        state      <= DONE;
                     end else begin
                        o_tm_direction <= DIR_UP;
                        state          <= UP;
                     end
                  end
               end
               DONE: begin
                  o_tm_reset     <= 1'b1;
                  o_tm_direction <= DIR_UP;
                  state          <= IDLE;
               end
               default: begin
                  o_tm_reset     <= 1'b1;
                  o_tm_direction <= DIR_UP;
                  o_busy         <= 1'b0;
                  state          <= IDLE;
               end
            endcase
         end
      end
   end

`ifdef COUNTER_SWEEP_CHK_EN
   logic chk_en;

   assign chk_en = (state == UP) || (state == DOWN) || (state == DONE);

   counter_sweep_chk #(
      .COUNT_WD(COUNT_WD)
   ) u_chk (
      .i_clk          (i_clk),
      .i_rstb         (i_rstb),
      .i_clear        (start_ok),
      .i_chk_en       (chk_en),
      .i_tm_reset     (o_tm_reset),
      .i_tm_direction (o_tm_direction),
      .i_count        (i_count),
      .o_mismatch     (o_mismatch)
   );
`endif

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer for the `counter` block. It drives that block's `i_tm_reset` and `i_tm_direction` to produce a programmed number of triangle sweeps: 0 -> LIMIT -> 0. It watches `o_count` as feedback and reports busy, done and sweep progress. It sits beside `counter` inside the test-mode wrapper, and the cocotb bench controls it.

Parameters:
COUNT_WD, 16, width of the counter and the limit
SWEEP_WD, 8, width of the sweep-count request and the progress output

Ports:
i_clk  in  1  clock
i_rstb  in  1  asynchronous active-low reset
i_start  in  1  single-cycle start request
i_abort  in  1  abort of the current run; level, sampled each cycle
i_limit  in  COUNT_WD  sweep peak value; sampled on an accepted start
i_num_sweeps  in  SWEEP_WD  number of sweeps; sampled on an accepted start
i_count  in  COUNT_WD  feedback from `counter.o_count`
o_tm_reset  out  1  drives `counter.i_tm_reset`
o_tm_direction  out  1  drives `counter.i_tm_direction`; 1 = up, 0 = down
o_busy  out  1  high from CLEAR through DOWN
o_done  out  1  one-cycle pulse at normal completion
o_start_err  out  1  one-cycle pulse when a start is rejected
o_sweep_cnt  out  SWEEP_WD  number of completed sweeps in the current or last run

Behaviour:
- Counter contract (fixed):
  - `i_tm_reset`=1 clears the count on the next edge.
  - Otherwise the count steps by ±1 per clock, per `i_tm_direction`.
- All outputs are registered. Reset values: `o_tm_reset`=1, `o_tm_direction`=1, all other outputs 0, state IDLE.
- FSM states: IDLE, CLEAR, UP, DOWN, DONE.
- IDLE:
  - `o_tm_reset`=1.
  - On `i_start` with `i_limit`!=0 and `i_num_sweeps`!=0: latch `lim_q` and `nsw_q`, clear `o_sweep_cnt`, go to CLEAR.
  - On `i_start` with either value 0: stay in IDLE and pulse `o_start_err` the next cycle.
- CLEAR: one cycle with `o_tm_reset`=1, then go to UP.
- UP:
  - `o_tm_reset`=0, `o_tm_direction`=1.
  - When `i_count`==`lim_q`-1, go to DOWN. The count therefore reaches `lim_q` on the same edge that direction goes to 0, so the peak is held for exactly one sample.
- DOWN:
  - `o_tm_direction`=0.
  - When `i_count`==1: increment `o_sweep_cnt`.
  - If the new count equals `nsw_q`, go to DONE; otherwise go to UP.
- DONE: `o_tm_reset`=1, `o_done`=1 for one cycle, then go to IDLE.
- Sweep period is 2·`lim_q` cycles. Latency from start-sample edge to the first count increment is 3 edges.
- `lim_q`=1 is legal: UP and DOWN each last one cycle.
- `i_start` while busy is ignored, with no error pulse.
- `i_abort` in any non-IDLE state:
  - Next state is IDLE and `o_tm_reset`=1.
  - No `o_done` pulse; `o_sweep_cnt` holds its value.
  - Abort takes priority over every other transition, including the DOWN -> DONE transition in the same cycle.
- Asynchronous reset mid-run returns the block to reset values immediately. The counter is then held cleared by `o_tm_reset`=1.
- `o_sweep_cnt` saturates at all-ones; it cannot wrap because it is bounded by `nsw_q`.
- `i_limit` and `i_num_sweeps` changing mid-run have no effect.

Optional Feature:
- Macro: COUNTER_SWEEP_CHK_EN.
- With the macro defined:
  - Adds output `o_mismatch` (1 bit, sticky, reset 0, cleared on an accepted start).
  - An internal predictor models the expected count from the driven `o_tm_reset`/`o_tm_direction`.
  - From the UP state onward, any cycle where `i_count` differs from the prediction sets `o_mismatch`.
- Without the macro: the port and the logic are absent.

Decomposition:
- Package `counter_ctrl_pkg` holds:
  - `sweep_state_e`, the enum for the five states;
  - `DIR_UP` = 1 and `DIR_DOWN` = 0.
- Sub-module `counter_sweep_chk` holds the predictor and mismatch flag. It is instantiated only under COUNTER_SWEEP_CHK_EN.

Test Plan:
- Start with `i_limit`=4 and `i_num_sweeps`=2 -> `i_count` sequence 0,1,2,3,4,3,2,1,0,1,2,3,4,3,2,1,0; `o_sweep_cnt` steps 1 then 2; `o_done` pulses once; `o_busy` falls with it.
- Start with `i_limit`=1 and `i_num_sweeps`=3 -> count toggles 0,1,0,1,0,1,0; `o_done` pulses after the third return to 0.
- Start with `i_limit`=0, then with `i_num_sweeps`=0 -> an `o_start_err` pulse each time; `o_busy` stays 0; the counter stays at 0.
- `i_abort` asserted at count 3 of the second sweep (`i_limit`=5, `i_num_sweeps`=4) -> IDLE next cycle; `o_tm_reset`=1; count 0 after one edge; `o_sweep_cnt`=1; no `o_done`.
- A second `i_start` during UP, then `i_rstb` low mid-DOWN -> the second start is ignored; the reset returns all outputs to reset values asynchronously.
- With CHK_EN defined, force `i_count` off by one for a single cycle -> `o_mismatch`=1 stays set until the next accepted start.
